mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one single-ported memory bus between the CPU instruction port and data port. For each CPU step, the arbiter performs the instruction fetch, and the data access when one is requested, as sequential bus transactions. It then asserts both CPU valids together for exactly one cycle, so the CPU's clock enable advances the pipeline once. It sits between the cpu top level and the unified memory/bus slave.

Parameters:
D_FIRST, 0, 1 = data access issued before instruction fetch in each step; 0 = fetch first.
TIMEOUT, 255, bus cycles without ack before a transaction is aborted; 0 disables the timeout.
TO_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  asynchronous reset, active-high.
i_addr_i  in  32  CPU instruction address; held stable while o_valid_i is low.
o_valid_i  out  1  instruction data valid; one-cycle pulse in DONE.
o_data_i  out  32  fetched instruction, latched.
i_addr_d  in  32  CPU data address.
i_we_d  in  4  CPU byte write enables.
i_rd_d  in  1  CPU data read request.
i_data_d  in  32  CPU write data.
o_valid_d  out  1  data side valid; one-cycle pulse in DONE, identical timing to o_valid_i.
o_data_d  out  32  read data, latched; 0 after a write or when there is no access.
o_bus_addr  out  32  bus address, registered.
o_bus_we  out  4  bus byte enables, registered.
o_bus_rd  out  1  bus read strobe, registered.
o_bus_wdata  out  32  bus write data, registered.
o_bus_req  out  1  transaction request, registered.
i_bus_rdata  in  32  bus read data; sampled with ack.
i_bus_ack  in  1  transaction complete; sampled at the rising edge while o_bus_req=1.
o_bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset: all outputs 0; state IDLE; timeout counter 0; latched data 0. Asserting i_rst mid-transaction drops o_bus_req immediately; the aborted transaction is not replayed.
- States:
  - IDLE: one cycle after reset release.
  - I_REQ: instruction fetch.
  - D_REQ: data access.
  - DONE: valid pulse.
- Transition order, D_FIRST=0:
  - IDLE -> I_REQ.
  - I_REQ on ack -> D_REQ if a data access is pending, else DONE.
  - D_REQ on ack -> DONE.
  - DONE -> I_REQ.
- Transition order, D_FIRST=1:
  - IDLE and DONE -> D_REQ if a data access is pending, else I_REQ.
  - D_REQ -> I_REQ on ack.
  - I_REQ -> DONE on ack.
- Data access pending: (i_rd_d | (|i_we_d)), sampled in the cycle the arbiter decides to enter D_REQ.
- Bus signals are loaded in the entry cycle of a REQ state and held constant until ack or abort:
  - I_REQ: o_bus_addr=i_addr_i, o_bus_rd=1, o_bus_we=0.
  - D_REQ: o_bus_addr=i_addr_d, o_bus_we=i_we_d, o_bus_rd=i_rd_d & ~(|i_we_d), o_bus_wdata=i_data_d.
- Read and write set together: the write wins and o_bus_rd=0.
- On ack: o_bus_req, o_bus_we and o_bus_rd go to 0 at that edge. i_bus_rdata is latched into o_data_i (I_REQ) or into o_data_d (D_REQ read; 0 for a write).
- Ack is accepted in the first cycle of o_bus_req (zero-wait slave). An ack seen while o_bus_req=0 is ignored.
- Latency, zero-wait slave:
  - 2 cycles per step (REQ, DONE) without a data access.
  - 3 cycles per step with a data access.
  - Each extra wait cycle adds 1.
- DONE: o_valid_i=o_valid_d=1 for exactly one cycle; 0 in all other states. o_data_i/o_data_d hold their values until overwritten by the next transaction.
- Timeout:
  - The counter clears on REQ entry and increments each REQ cycle without ack.
  - When count==TIMEOUT-1 with no ack, the transaction is aborted: req drops, the affected data is latched as 0 (instruction 0 = bubble), o_bus_err is set, and the FSM proceeds as if acked.
  - o_bus_err is cleared only by reset.
  - An ack arriving in the same cycle as the timeout wins: no error, real data is latched.
- Address change while stalled is illegal; the values sampled at REQ entry are used.

Test Plan:
- Reset release with the slave acking immediately, D_FIRST=0, no data access, i_addr_i=0x0 and rdata=0x00000013 -> IDLE, I_REQ with addr 0x0 and rd=1, then DONE with o_valid_i=o_valid_d=1 and o_data_i=0x13; the 2-cycle step repeats.
- Load step: i_rd_d=1, i_addr_d=0x100, slave returning 0xDEADBEEF with 2 wait cycles -> fetch then D_REQ with addr 0x100 held for 3 cycles; DONE has o_data_d=0xDEADBEEF.
- Store step: i_we_d=4'b0011 with i_rd_d=1, wdata 0x1234 -> D_REQ with o_bus_we=0011, o_bus_rd=0, o_bus_wdata=0x1234; o_data_d=0.
- D_FIRST=1 with a pending load -> bus order is the data address, then the instruction address; both valids rise in the same single cycle.
- TIMEOUT=4 with the slave never acking -> req is high for 4 cycles then drops; o_bus_err=1 sticky; o_data_i=0; DONE pulse follows. A separate run acks on the 4th cycle: no error.
- i_rst pulsed mid-D_REQ (asynchronous, between edges) -> o_bus_req and both valids go to 0 immediately; after release the sequence restarts from IDLE, then I_REQ.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: time-shares one single-ported memory bus between the CPU
// instruction port and data port. Each CPU step performs a fetch and an
// optional data access as back-to-back bus transactions, then pulses both
// CPU valids together for one cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | first cycle after reset release, no bus activity
// S_I_REQ | instruction fetch transaction on the bus
// S_D_REQ | data load/store transaction on the bus
// S_DONE  | one-cycle valid pulse to the CPU
module mem_arbiter #(
  parameter int D_FIRST = 0,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_addr_i,
  output logic        o_valid_i,
  output logic [31:0] o_data_i,
  input  logic [31:0] i_addr_d,
  input  logic [3:0]  i_we_d,
  input  logic        i_rd_d,
  input  logic [31:0] i_data_d,
  output logic        o_valid_d,
  output logic [31:0] o_data_d,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_we,
  output logic        o_bus_rd,
  output logic [31:0] o_bus_wdata,
  output logic        o_bus_req,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ack,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_I_REQ = 2'd1,
    S_D_REQ = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // A zero TIMEOUT disables aborts; the compare value is then unused.
  localparam logic            TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT != 0) ? TIMEOUT - 1 : 0);
  localparam logic            DF      = (D_FIRST != 0);

  state_t          r_state;
  state_t          w_next;
  logic [TO_W-1:0] r_cnt;
  logic [31:0]     r_bus_addr;
  logic [3:0]      r_bus_we;
  logic            r_bus_rd;
  logic [31:0]     r_bus_wdata;
  logic            r_bus_req;
  logic            r_bus_err;
  logic [31:0]     r_data_i;
  logic [31:0]     r_data_d;

  logic w_dpend;
  logic w_ack;
  logic w_to;
  logic w_fin;
  logic w_enter_i;
  logic w_enter_d;
  logic w_skip_d;
  logic w_valid;

  // r_bus_req is high exactly while a REQ state owns the bus, so an ack
  // outside a transaction is ignored; a same-cycle ack beats the timeout.
  assign w_dpend   = i_rd_d | (|i_we_d);
  assign w_ack     = r_bus_req & i_bus_ack;
  assign w_to      = TO_EN & r_bus_req & ~i_bus_ack & (r_cnt == TO_LAST);
  assign w_fin     = w_ack | w_to;
  assign w_enter_i = (w_next == S_I_REQ) && (r_state != S_I_REQ);
  assign w_enter_d = (w_next == S_D_REQ) && (r_state != S_D_REQ);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode, valid pulse, and detection of a step with no data access.
  always_comb begin
    w_next   = r_state;
    w_valid  = 1'b0;
    w_skip_d = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_valid = (r_state == S_DONE);
        if (DF && w_dpend) begin
          w_next = S_D_REQ;
        end else begin
          w_next   = S_I_REQ;
          w_skip_d = DF;
        end
      end
      S_I_REQ: begin
        if (w_fin) begin
          if (!DF && w_dpend) begin
            w_next = S_D_REQ;
          end else begin
            w_next   = S_DONE;
            w_skip_d = !DF;
          end
        end
      end
      S_D_REQ: begin
        if (w_fin) w_next = DF ? S_I_REQ : S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Bus outputs: captured on REQ entry, held until ack/abort. Entry wins over
  // completion so back-to-back transactions keep req asserted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bus_addr  <= '0;
      r_bus_we    <= '0;
      r_bus_rd    <= 1'b0;
      r_bus_wdata <= '0;
      r_bus_req   <= 1'b0;
    end else if (w_enter_i) begin
      r_bus_addr  <= i_addr_i;
      r_bus_we    <= '0;
      r_bus_rd    <= 1'b1;
      r_bus_wdata <= '0;
      r_bus_req   <= 1'b1;
    end else if (w_enter_d) begin
      r_bus_addr  <= i_addr_d;
      r_bus_we    <= i_we_d;
      r_bus_rd    <= i_rd_d & ~(|i_we_d);
      r_bus_wdata <= i_data_d;
      r_bus_req   <= 1'b1;
    end else if (w_fin) begin
      r_bus_we    <= '0;
      r_bus_rd    <= 1'b0;
      r_bus_req   <= 1'b0;
    end
  end

  // Timeout counter: cleared on REQ entry, counts REQ cycles without ack.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                        r_cnt <= '0;
    else if (w_enter_i || w_enter_d)  r_cnt <= '0;
    else if (r_bus_req && !w_fin)     r_cnt <= r_cnt + 1'b1;
  end

  // Returned data latches; aborted fetches become a zero bubble, writes and
  // skipped data accesses leave zero on the data side.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data_i <= '0;
      r_data_d <= '0;
    end else begin
      if (r_state == S_I_REQ && w_fin) r_data_i <= w_ack ? i_bus_rdata : '0;
      if (r_state == S_D_REQ && w_fin) r_data_d <= (w_ack && r_bus_rd) ? i_bus_rdata : '0;
      else if (w_skip_d)               r_data_d <= '0;
    end
  end

  // Sticky timeout error, cleared only by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_bus_err <= 1'b0;
    else if (w_to) r_bus_err <= 1'b1;
  end

  assign o_valid_i   = w_valid;
  assign o_valid_d   = w_valid;
  assign o_data_i    = r_data_i;
  assign o_data_d    = r_data_d;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_we    = r_bus_we;
  assign o_bus_rd    = r_bus_rd;
  assign o_bus_wdata = r_bus_wdata;
  assign o_bus_req   = r_bus_req;
  assign o_bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 is fetch-first with a short timeout,
// instance 1 is data-first. A slave model acks after a programmable number
// of wait cycles; expected bus transactions and valid pulses are queued by
// the stimulus and popped by monitors when the DUT presents them.
module tb_mem_arbiter;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  we;
    logic        rd;
    logic [31:0] wd;
    int          cyc;
  } bus_t;

  typedef struct {
    logic [31:0] di;
    logic [31:0] dd;
    int          gap;
  } val_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [2];
  logic [31:0] addr_i   [2];
  logic [31:0] addr_d   [2];
  logic [3:0]  we_d     [2];
  logic        rd_d     [2];
  logic [31:0] wdata_d  [2];
  logic        valid_i  [2];
  logic        valid_d  [2];
  logic [31:0] data_i   [2];
  logic [31:0] data_d   [2];
  logic [31:0] bus_addr [2];
  logic [3:0]  bus_we   [2];
  logic        bus_rd   [2];
  logic [31:0] bus_wdata[2];
  logic        bus_req  [2];
  logic [31:0] rdata    [2];
  logic        ack      [2];
  logic        err      [2];

  int wait_c[2];
  bit never [2];
  int s_cnt [2];
  bit s_was [2];
  int gcnt  [2];

  bus_t bus_q[$];
  val_t val_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  mem_arbiter #(.D_FIRST(0), .TIMEOUT(4), .TO_W(8)) u_a (
    .i_clk(clk), .i_rst(rst[0]),
    .i_addr_i(addr_i[0]), .o_valid_i(valid_i[0]), .o_data_i(data_i[0]),
    .i_addr_d(addr_d[0]), .i_we_d(we_d[0]), .i_rd_d(rd_d[0]), .i_data_d(wdata_d[0]),
    .o_valid_d(valid_d[0]), .o_data_d(data_d[0]),
    .o_bus_addr(bus_addr[0]), .o_bus_we(bus_we[0]), .o_bus_rd(bus_rd[0]),
    .o_bus_wdata(bus_wdata[0]), .o_bus_req(bus_req[0]),
    .i_bus_rdata(rdata[0]), .i_bus_ack(ack[0]), .o_bus_err(err[0])
  );

  mem_arbiter #(.D_FIRST(1), .TIMEOUT(255), .TO_W(8)) u_b (
    .i_clk(clk), .i_rst(rst[1]),
    .i_addr_i(addr_i[1]), .o_valid_i(valid_i[1]), .o_data_i(data_i[1]),
    .i_addr_d(addr_d[1]), .i_we_d(we_d[1]), .i_rd_d(rd_d[1]), .i_data_d(wdata_d[1]),
    .o_valid_d(valid_d[1]), .o_data_d(data_d[1]),
    .o_bus_addr(bus_addr[1]), .o_bus_we(bus_we[1]), .o_bus_rd(bus_rd[1]),
    .o_bus_wdata(bus_wdata[1]), .o_bus_req(bus_req[1]),
    .i_bus_rdata(rdata[1]), .i_bus_ack(ack[1]), .o_bus_err(err[1])
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : 32'h13 + a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Slave model plus bus monitor: acks after wait_c cycles, checks each acked transaction.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!bus_req[k]) begin
        s_cnt[k] = 0;
        ack[k]   = 1'b0;
        rdata[k] = 32'h0;
      end else begin
        if (!s_was[k] || ack[k]) s_cnt[k] = 0;
        else                     s_cnt[k] = s_cnt[k] + 1;
        ack[k]   = !never[k] && (s_cnt[k] >= wait_c[k]);
        rdata[k] = ack[k] ? mem_f(bus_addr[k]) : 32'h0;
        if (ack[k]) begin
          if (bus_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL u%0d_bus_unexpected: got addr 0x%08h, expected no transaction", k, bus_addr[k]);
          end else begin
            bus_t e;
            e = bus_q.pop_front();
            chk($sformatf("u%0d_bus_addr", k), bus_addr[k], e.a);
            chk($sformatf("u%0d_bus_we", k), 32'(bus_we[k]), 32'(e.we));
            chk($sformatf("u%0d_bus_rd", k), 32'(bus_rd[k]), 32'(e.rd));
            if (e.we != 4'h0) chk($sformatf("u%0d_bus_wdata", k), bus_wdata[k], e.wd);
            chk($sformatf("u%0d_bus_cycles", k), 32'(s_cnt[k] + 1), 32'(e.cyc));
          end
        end
      end
      s_was[k] = bus_req[k];
    end
  end

  // Valid monitor: each pulse pops one expected step result.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      gcnt[k] = gcnt[k] + 1;
      if (valid_i[k] || valid_d[k]) begin
        chk($sformatf("u%0d_valid_i", k), 32'(valid_i[k]), 32'd1);
        chk($sformatf("u%0d_valid_d", k), 32'(valid_d[k]), 32'd1);
        if (val_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL u%0d_valid_unexpected: got data_i 0x%08h, expected no pulse", k, data_i[k]);
        end else begin
          val_t e;
          e = val_q.pop_front();
          chk($sformatf("u%0d_data_i", k), data_i[k], e.di);
          chk($sformatf("u%0d_data_d", k), data_d[k], e.dd);
          if (e.gap != 0) chk($sformatf("u%0d_step_cycles", k), 32'(gcnt[k]), 32'(e.gap));
        end
        gcnt[k] = 0;
      end
    end
  end

  task automatic drive(input int k, input logic [31:0] ai, input logic [31:0] ad,
                       input logic [3:0] we, input logic rd, input logic [31:0] wd,
                       input int w, input bit nv);
    addr_i[k]  = ai;
    addr_d[k]  = ad;
    we_d[k]    = we;
    rd_d[k]    = rd;
    wdata_d[k] = wd;
    wait_c[k]  = w;
    never[k]   = nv;
  endtask

  task automatic exp_bus(input logic [31:0] a, input logic [3:0] we, input logic rd,
                         input logic [31:0] wd, input int cyc);
    bus_t e;
    e.a = a; e.we = we; e.rd = rd; e.wd = wd; e.cyc = cyc;
    bus_q.push_back(e);
  endtask

  task automatic exp_val(input logic [31:0] di, input logic [31:0] dd, input int gap);
    val_t e;
    e.di = di; e.dd = dd; e.gap = gap;
    val_q.push_back(e);
  endtask

  task automatic wait_valid(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid_i[k] && n < 60);
    if (!valid_i[k]) begin
      n_checks++;
      n_errors++;
      $display("FAIL u%0d_valid_timeout: got no valid in 60 cycles, expected a pulse", k);
    end
  endtask

  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; ack[k] = 1'b0; rdata[k] = 32'h0;
      s_cnt[k] = 0; s_was[k] = 1'b0; gcnt[k] = 0;
    end
    drive(0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 0, 1'b0);
    drive(1, 32'h0, 32'h200, 4'h0, 1'b1, 32'h0, 0, 1'b0);
    repeat (3) @(negedge clk);

    chk("rst_bus_req", 32'(bus_req[0]), 32'd0);
    chk("rst_bus_addr", bus_addr[0], 32'h0);
    chk("rst_valid", 32'(valid_i[0]), 32'd0);
    chk("rst_data_i", data_i[0], 32'h0);
    chk("rst_err", 32'(err[0]), 32'd0);

    // Instance 0: fetch-first, TIMEOUT=4.
    exp_bus(32'h0, 4'h0, 1'b1, 32'h0, 1);
    exp_val(32'h13, 32'h0, 0);
    rst[0] = 1'b0;
    chk("u0_idle_req", 32'(bus_req[0]), 32'd0);
    @(posedge clk); #1;
    chk("u0_ireq_req", 32'(bus_req[0]), 32'd1);
    chk("u0_ireq_rd", 32'(bus_rd[0]), 32'd1);
    wait_valid(0);

    drive(0, 32'h4, 32'h0, 4'h0, 1'b0, 32'h0, 0, 1'b0);
    exp_bus(32'h4, 4'h0, 1'b1, 32'h0, 1);
    exp_val(32'h17, 32'h0, 2);
    wait_valid(0);

    drive(0, 32'h8, 32'h100, 4'h0, 1'b1, 32'h0, 2, 1'b0);
    exp_bus(32'h8, 4'h0, 1'b1, 32'h0, 3);
    exp_bus(32'h100, 4'h0, 1'b1, 32'h0, 3);
    exp_val(32'h1B, 32'hDEADBEEF, 7);
    wait_valid(0);

    drive(0, 32'hC, 32'h0, 4'h0, 1'b0, 32'h0, 0, 1'b0);
    exp_bus(32'hC, 4'h0, 1'b1, 32'h0, 1);
    exp_val(32'h1F, 32'h0, 2);
    wait_valid(0);

    drive(0, 32'h10, 32'h104, 4'b0011, 1'b1, 32'h1234, 0, 1'b0);
    exp_bus(32'h10, 4'h0, 1'b1, 32'h0, 1);
    exp_bus(32'h104, 4'b0011, 1'b0, 32'h1234, 1);
    exp_val(32'h23, 32'h0, 3);
    wait_valid(0);

    drive(0, 32'h14, 32'h0, 4'h0, 1'b0, 32'h0, 3, 1'b0);
    exp_bus(32'h14, 4'h0, 1'b1, 32'h0, 4);
    exp_val(32'h27, 32'h0, 5);
    wait_valid(0);
    chk("u0_err_ack_at_limit", 32'(err[0]), 32'd0);

    drive(0, 32'h18, 32'h0, 4'h0, 1'b0, 32'h0, 0, 1'b1);
    exp_val(32'h0, 32'h0, 5);
    wait_valid(0);
    chk("u0_err_timeout", 32'(err[0]), 32'd1);

    drive(0, 32'h1C, 32'h0, 4'h0, 1'b0, 32'h0, 0, 1'b0);
    exp_bus(32'h1C, 4'h0, 1'b1, 32'h0, 1);
    exp_val(32'h2F, 32'h0, 2);
    wait_valid(0);
    chk("u0_err_sticky", 32'(err[0]), 32'd1);

    // Reset asserted between edges during the data access.
    drive(0, 32'h20, 32'h100, 4'h0, 1'b1, 32'h0, 3, 1'b0);
    exp_bus(32'h20, 4'h0, 1'b1, 32'h0, 4);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(bus_req[0] && bus_addr[0] == 32'h100) && n < 40);
    chk("u0_dreq_addr", bus_addr[0], 32'h100);
    #2;
    rst[0] = 1'b1;
    #1;
    chk("u0_arst_req", 32'(bus_req[0]), 32'd0);
    chk("u0_arst_valid", 32'(valid_i[0]), 32'd0);
    chk("u0_arst_err", 32'(err[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    drive(0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 0, 1'b0);
    exp_bus(32'h0, 4'h0, 1'b1, 32'h0, 1);
    exp_val(32'h13, 32'h0, 0);
    rst[0] = 1'b0;
    chk("u0_restart_idle", 32'(bus_req[0]), 32'd0);
    @(posedge clk); #1;
    chk("u0_restart_ireq", 32'(bus_req[0]), 32'd1);
    chk("u0_restart_addr", bus_addr[0], 32'h0);
    wait_valid(0);
    rst[0] = 1'b1;

    // Instance 1: data-first.
    @(negedge clk);
    exp_bus(32'h200, 4'h0, 1'b1, 32'h0, 1);
    exp_bus(32'h0, 4'h0, 1'b1, 32'h0, 1);
    exp_val(32'h13, 32'h213, 0);
    rst[1] = 1'b0;
    wait_valid(1);

    drive(1, 32'h4, 32'h0, 4'h0, 1'b0, 32'h0, 0, 1'b0);
    exp_bus(32'h4, 4'h0, 1'b1, 32'h0, 1);
    exp_val(32'h17, 32'h0, 2);
    wait_valid(1);

    drive(1, 32'h8, 32'h204, 4'hF, 1'b0, 32'hCAFE, 0, 1'b0);
    exp_bus(32'h204, 4'hF, 1'b0, 32'hCAFE, 1);
    exp_bus(32'h8, 4'h0, 1'b1, 32'h0, 1);
    exp_val(32'h1B, 32'h0, 3);
    wait_valid(1);

    drive(1, 32'hC, 32'h100, 4'h0, 1'b1, 32'h0, 1, 1'b0);
    exp_bus(32'h100, 4'h0, 1'b1, 32'h0, 2);
    exp_bus(32'hC, 4'h0, 1'b1, 32'h0, 2);
    exp_val(32'h1F, 32'hDEADBEEF, 5);
    wait_valid(1);
    rst[1] = 1'b1;

    repeat (3) @(negedge clk);
    chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    chk("valid_queue_drained", 32'(val_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
